// File: rtl/gg_emu_rm_sched.sv
`timescale 1ns/1ps
// Packet-granular round-robin sharing of one emulation-prevention remover between NREQ requesters.
// A tag FIFO shadows the words in flight so each output word carries its requester id and last flag.
module gg_emu_rm_sched #(
  parameter int  NREQ  = 4,
  parameter int  DEPTH = 8,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ*128-1:0]  req_data,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rm_clear,
  output logic [127:0]         rm_iport,
  output logic                 rm_iport_valid,
  input  logic                 rm_iport_ready,
  input  logic [127:0]         rm_oport,
  input  logic [15:0]          rm_flag,
  input  logic                 rm_oport_valid,
  output logic                 rm_oport_ready,
  output logic [127:0]         out_data,
  output logic [15:0]          out_flag,
  output logic [IDW-1:0]       out_id,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {CLR, ARB, XFER, DRAIN} state_t;
  state_t state, state_nxt;

  logic [IDW-1:0] ptr, gnt, arb_sel;
  logic           arb_hit;
  logic [IDW:0]   tag_mem [DEPTH];
  logic [IDW:0]   head;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           fifo_full, fifo_empty, push, pop, xfer;

  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign xfer       = (state == XFER) && !reset;

  // Descending scan so the requester nearest to ptr+1 is the one that sticks
  always_comb begin
    logic [IDW:0] sum;
    arb_hit = 1'b0;
    arb_sel = ptr;
    sum     = '0;
    for (int i = NREQ; i >= 1; i--) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (req_valid[sum[IDW-1:0]]) begin
        arb_hit = 1'b1;
        arb_sel = sum[IDW-1:0];
      end
    end
  end

  assign rm_iport       = req_data[32'(gnt) * 128 +: 128];
  assign rm_iport_valid = xfer && req_valid[gnt] && !fifo_full;
  assign push           = rm_iport_valid && rm_iport_ready;
  assign pop            = rm_oport_valid && out_ready && !fifo_empty;

  always_comb begin
    req_ready = '0;
    if (xfer && rm_iport_ready && !fifo_full) req_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLR:     state_nxt = ARB;
      ARB:     if (arb_hit) state_nxt = XFER;
      XFER:    if (push && req_last[gnt]) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty || (count == CW'(1) && pop)) state_nxt = CLR;
      default: state_nxt = CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= CLR;
      ptr    <= IDW'(NREQ - 1);
      gnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ARB && arb_hit) begin
        gnt <= arb_sel;
        ptr <= arb_sel;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      // Remover produced a word nobody asked for
      if (rm_oport_valid && fifo_empty) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= {gnt, req_last[gnt]};
  end

  assign head           = tag_mem[rd_ptr];
  assign out_id         = fifo_empty ? '0 : head[IDW:1];
  assign out_last       = !fifo_empty && head[0];
  assign out_data       = rm_oport;
  assign out_flag       = rm_flag;
  assign out_valid      = rm_oport_valid;
  assign rm_oport_ready = out_ready;
  assign rm_clear       = (state == CLR) && !reset;
  assign busy           = (state != ARB) && !reset;

endmodule

// File: tb/tb_gg_emu_rm_sched.sv
`timescale 1ns/1ps
// Bench for gg_emu_rm_sched: requester queues and a 2-cycle remover model driven each cycle,
// output words logged with their cycle, then compared against hand-built expectations.
module tb_gg_emu_rm_sched;
  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int IDW   = 2;

  logic                clk, reset;
  logic [NREQ*128-1:0] req_data;
  logic [NREQ-1:0]     req_valid, req_last, req_ready;
  logic                rm_clear;
  logic [127:0]        rm_iport;
  logic                rm_iport_valid, rm_iport_ready;
  logic [127:0]        rm_oport;
  logic [15:0]         rm_flag;
  logic                rm_oport_valid, rm_oport_ready;
  logic [127:0]        out_data;
  logic [15:0]         out_flag;
  logic [IDW-1:0]      out_id;
  logic                out_last, out_valid, out_ready, busy, err;
  logic                mdl_valid, inject;

  typedef struct packed {logic [127:0] d; logic last;} wrd_t;
  typedef struct packed {logic [127:0] d; logic [31:0] c;} mq_t;
  typedef struct packed {logic [127:0] d; logic [15:0] f; logic [IDW-1:0] id; logic last; logic [31:0] c;} log_t;
  typedef struct {int r; int len; int exp_id;} vec_t;

  wrd_t rq [NREQ][$];
  mq_t  mq [$];
  log_t out_log [$];
  int   clr_log [$];
  int   cyc, acc, checks, errors;

  logic [NREQ-1:0] rfire;
  logic            in_fire, out_fire, clr_s, rst_s;
  logic [127:0]    w;

  gg_emu_rm_sched #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .rm_clear(rm_clear), .rm_iport(rm_iport), .rm_iport_valid(rm_iport_valid),
    .rm_iport_ready(rm_iport_ready), .rm_oport(rm_oport), .rm_flag(rm_flag),
    .rm_oport_valid(rm_oport_valid), .rm_oport_ready(rm_oport_ready),
    .out_data(out_data), .out_flag(out_flag), .out_id(out_id), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
  );

  assign rm_oport_valid = mdl_valid | inject;
  assign rm_iport_ready = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag a 03 byte that follows two 00 bytes inside the word (byte 0 is the MSB byte)
  function automatic logic [15:0] epb_flags(input logic [127:0] d);
    logic [15:0] f;
    f = '0;
    for (int k = 2; k < 16; k++)
      if (d[127-8*k -: 8] == 8'h03 && d[135-8*k -: 8] == 8'h00 && d[143-8*k -: 8] == 8'h00)
        f[15-k] = 1'b1;
    return f;
  endfunction

  function automatic logic [127:0] word(input int r, input int tag, input int k);
    return {r[7:0], tag[7:0], k[7:0], 104'h5A5A5A5A5A5A5A5A5A5A5A5A5A};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input int r, input int len, input int tag);
    for (int k = 0; k < len; k++) rq[r].push_back('{d: word(r, tag, k), last: (k == len - 1)});
  endtask

  task automatic wait_out(input string nm, input int n, input int budget);
    int t;
    t = 0;
    while (out_log.size() < n && t < budget) begin
      tick();
      t++;
    end
    chk({nm, "_count"}, 128'(out_log.size()), 128'(n));
  endtask

  task automatic chk_word(input string nm, input int i, input logic [127:0] d, input int id, input logic last);
    if (i >= out_log.size()) begin
      chk($sformatf("%s[%0d]_present", nm, i), 128'(out_log.size()), 128'(i + 1));
      return;
    end
    chk($sformatf("%s[%0d]_data", nm, i), out_log[i].d, d);
    chk($sformatf("%s[%0d]_id", nm, i), 128'(out_log[i].id), 128'(id));
    chk($sformatf("%s[%0d]_last", nm, i), 128'(out_log[i].last), 128'(last));
    chk($sformatf("%s[%0d]_flag", nm, i), 128'(out_log[i].f), 128'(epb_flags(d)));
  endtask

  // Requesters and remover model: sample mid-cycle, update just after the edge
  initial begin
    cyc = 0; acc = 0;
    req_valid = '0; req_last = '0; req_data = '0;
    mdl_valid = 1'b0; rm_oport = '0; rm_flag = '0;
    forever begin
      @(negedge clk);
      in_fire  = rm_iport_valid && rm_iport_ready;
      out_fire = rm_oport_valid && rm_oport_ready;
      rfire    = req_valid & req_ready;
      clr_s    = rm_clear;
      rst_s    = reset;
      w        = rm_iport;
      if (in_fire) acc++;
      if (clr_s) clr_log.push_back(cyc);
      if (out_valid && out_ready)
        out_log.push_back('{d: out_data, f: out_flag, id: out_id, last: out_last, c: cyc});
      @(posedge clk);
      #1;
      cyc++;
      if (rst_s || clr_s) mq.delete();
      else begin
        if (out_fire && mq.size() > 0) void'(mq.pop_front());
        if (in_fire) mq.push_back('{d: w, c: cyc});
      end
      if (mq.size() > 0 && cyc >= int'(mq[0].c) + 2) begin
        mdl_valid = 1'b1;
        rm_oport  = mq[0].d;
        rm_flag   = epb_flags(mq[0].d);
      end else mdl_valid = 1'b0;
      for (int r = 0; r < NREQ; r++) begin
        if (rfire[r] && rq[r].size() > 0) void'(rq[r].pop_front());
        if (rq[r].size() > 0) begin
          req_valid[r]            = 1'b1;
          req_data[r*128 +: 128]  = rq[r][0].d;
          req_last[r]             = rq[r][0].last;
        end else req_valid[r] = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    vec_t tbl [4];
    int   e_r [4];
    int   e_l [4];
    int   n, t;
    logic [127:0] d;
    checks = 0; errors = 0;
    reset = 1'b1; out_ready = 1'b1; inject = 1'b0;
    tbl[0] = '{r: 2, len: 1, exp_id: 2};
    tbl[1] = '{r: 3, len: 4, exp_id: 3};
    tbl[2] = '{r: 1, len: 2, exp_id: 1};
    tbl[3] = '{r: 0, len: 3, exp_id: 0};
    e_r = '{1, 3, 1, 3};
    e_l = '{2, 3, 2, 3};

    // Reset values, then the single rm_clear pulse after release
    tick();
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_iport_valid", 128'(rm_iport_valid), 128'(0));
    chk("rst_rm_clear", 128'(rm_clear), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    tick(2);
    reset = 1'b0;
    #1;
    chk("post_rst_clear", 128'(rm_clear), 128'(1));
    chk("post_rst_busy", 128'(busy), 128'(1));
    tick();
    chk("arb_clear_low", 128'(rm_clear), 128'(0));
    chk("arb_busy_low", 128'(busy), 128'(0));

    // Single-requester packets from the table
    for (int v = 0; v < 4; v++) begin
      out_log.delete(); clr_log.delete();
      send(tbl[v].r, tbl[v].len, v);
      wait_out($sformatf("vec%0d", v), tbl[v].len, 100);
      for (int k = 0; k < tbl[v].len; k++)
        chk_word($sformatf("vec%0d", v), k, word(tbl[v].r, v, k), tbl[v].exp_id, k == tbl[v].len - 1);
      tick(3);
      chk($sformatf("vec%0d_clr_count", v), 128'(clr_log.size()), 128'(1));
      if (clr_log.size() > 0 && out_log.size() >= tbl[v].len)
        chk($sformatf("vec%0d_clr_cycle", v), 128'(clr_log[0]), 128'(out_log[tbl[v].len-1].c + 1));
      chk($sformatf("vec%0d_busy", v), 128'(busy), 128'(0));
    end

    // Requesters 1 and 3 competing with ptr=0: packets alternate 1,3,1,3
    out_log.delete();
    send(1, 2, 10); send(3, 3, 11); send(1, 2, 12); send(3, 3, 13);
    wait_out("rr", 10, 300);
    n = 0;
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < e_l[p]; k++) begin
        chk_word("rr", n, word(e_r[p], 10 + p, k), e_r[p], k == e_l[p] - 1);
        n++;
      end

    // Downstream stalled during a 10-word packet: input stops at FIFO depth
    tick(2);
    out_log.delete(); acc = 0; out_ready = 1'b0;
    send(0, 10, 20);
    tick(12);
    chk("stall_accepted", 128'(acc), 128'(DEPTH));
    chk("stall_iport_valid", 128'(rm_iport_valid), 128'(0));
    chk("stall_req_ready", 128'(req_ready), 128'(0));
    chk("stall_no_output", 128'(out_log.size()), 128'(0));
    out_ready = 1'b1;
    wait_out("stall", 10, 100);
    for (int k = 0; k < 10; k++) chk_word("stall", k, word(0, 20, k), 0, k == 9);

    // 24 words of 00 00 03 patterns from requester 2
    tick(3);
    out_log.delete();
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < 16; k++) d[127-8*k -: 8] = (k % 3 == 2) ? 8'h03 : 8'h00;
      d[7:0] = 8'(i);
      rq[2].push_back('{d: d, last: (i == 23)});
    end
    wait_out("epb", 24, 200);
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < 16; k++) d[127-8*k -: 8] = (k % 3 == 2) ? 8'h03 : 8'h00;
      d[7:0] = 8'(i);
      chk_word("epb", i, d, 2, i == 23);
    end
    chk("epb_no_err", 128'(err), 128'(0));

    // Spurious remover output while nothing is in flight
    tick(3);
    out_log.delete();
    inject = 1'b1;
    #1;
    chk("inj_out_valid", 128'(out_valid), 128'(1));
    chk("inj_out_id", 128'(out_id), 128'(0));
    chk("inj_out_last", 128'(out_last), 128'(0));
    tick();
    inject = 1'b0;
    chk("inj_err_set", 128'(err), 128'(1));
    tick(3);
    chk("inj_err_sticky", 128'(err), 128'(1));
    send(1, 1, 30);
    wait_out("inj", 2, 100);
    chk_word("inj", 1, word(1, 30, 0), 1, 1'b1);
    chk("inj_err_still", 128'(err), 128'(1));

    // Reset in the middle of a 5-word packet
    tick(3);
    acc = 0;
    send(3, 5, 40);
    t = 0;
    while (acc < 2 && t < 50) begin
      tick();
      t++;
    end
    chk("mid_accepted", 128'(acc), 128'(2));
    reset = 1'b1;
    tick();
    rq[3].delete();
    chk("mid_req_ready", 128'(req_ready), 128'(0));
    chk("mid_iport_valid", 128'(rm_iport_valid), 128'(0));
    chk("mid_err_cleared", 128'(err), 128'(0));
    chk("mid_busy", 128'(busy), 128'(0));
    tick();
    reset = 1'b0;
    #1;
    chk("mid_clear_pulse", 128'(rm_clear), 128'(1));
    tick();
    chk("mid_clear_end", 128'(rm_clear), 128'(0));
    out_log.delete();
    send(1, 2, 41);
    wait_out("after", 2, 100);
    for (int k = 0; k < 2; k++) chk_word("after", k, word(1, 41, k), 1, k == 1);
    chk("after_no_err", 128'(err), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
